wishbone_timer: RTL and testbench
=================================

# wishbone_timer

Wishbone responder holding a 64-bit machine timer (mtime/mtimecmp) with a prescaler and a level interrupt output. It sits on the core's Wishbone bus as a slave, at the other end from the core's Wishbone master. It answers the LSU's single-beat reads and writes, and its o_IRQ drives one of the core's i_MEI_n inputs.

## Interface
- ADDR_WIDTH, 32: width of i_ADDR; only i_ADDR[4:2] is decoded, and the interconnect gates i_STB per slave.
- PRESCALE_RST, 0: reset value of the PRESCALE register, 16 bits.
- i_CLK  in  1  single clock.
- i_RST  in  1  asynchronous active-high reset.
- i_ADDR  in  ADDR_WIDTH  byte address.
- i_DATA  in  32  write data.
- o_DATA  out  32  read data, valid while o_ACK=1.
- i_WE  in  1  1 = write.
- i_SEL  in  4  byte enables for writes; ignored for reads.
- i_STB  in  1  strobe.
- i_CYC  in  1  bus cycle.
- o_ACK  out  1  one-cycle acknowledge.
- i_TAGN  in  1  request tag.
- o_TAGN  out  1  i_TAGN echoed alongside o_ACK.
- o_IRQ  out  1  timer interrupt, level.

## Operation
- Register map by i_ADDR[4:2]:
  - 0 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTORELOAD. Remaining bits read 0.
  - 1 STATUS: bit0 PENDING. Writing 1 to bit0 clears it (W1C).
  - 2 PRESCALE[15:0].
  - 3 MTIME_LO, 4 MTIME_HI, 5 MTIMECMP_LO, 6 MTIMECMP_HI.
  - 7 is unmapped: reads return 0, writes are ignored, the access is still acked.
- Writes honour i_SEL per byte. Unselected bytes keep their value.
- Prescaler: a 16-bit counter pcnt runs while EN=1. When pcnt==PRESCALE, pcnt returns to 0 and a tick occurs. PRESCALE=0 gives a tick every cycle.
- Tick behaviour:
  - Normally mtime increments by 1 and wraps from 2^64-1 to 0.
  - With AUTORELOAD=1 and mtime==mtimecmp on the tick, mtime loads 0 instead.
- EN=0 freezes both pcnt and mtime.
- Bus write to MTIME_LO/HI: updates the selected bytes and wins over a tick in the same cycle. pcnt clears to 0.
- Read of MTIME_LO: returns mtime[31:0] and captures mtime[63:32] into a shadow register. Reads of MTIME_HI return the shadow, so a LO-then-HI read pair is tear-free.
- PENDING: set in any cycle where the registered mtime >= mtimecmp, as a 64-bit unsigned compare. It is sticky and cleared only by a W1C write. If set and clear happen in the same cycle, set wins.
- o_IRQ = PENDING & IRQ_EN, an AND of two flops.

## Timing
- Reset values:
  - Outputs: o_ACK=0, o_DATA=0, o_TAGN=0, o_IRQ=0.
  - Registers: CTRL=0, PENDING=0, PRESCALE=PRESCALE_RST, mtime=0, pcnt=0, shadow=0, mtimecmp=all-ones.
- Handshake, classic single beat:
  - A request is sampled when i_CYC & i_STB & ~o_ACK.
  - o_ACK is 1 on the following cycle for exactly one cycle. o_DATA and o_TAGN are registered with it.
  - A held i_STB is acked every other cycle; the master deasserts i_STB after ack.
  - Register writes take effect at the same edge that raises o_ACK.
- Latency: 1 cycle from request to ack. No wait states and no error/retry.
- Request dropped mid-cycle: if i_CYC falls in the ack cycle, the ack is still emitted and has no effect on state.
- Read data reflects register contents at the sampling edge, not after any same-edge update.
- Interrupt latency:
  - mtime reaches a value >= mtimecmp at edge N; PENDING and o_IRQ rise at edge N+1.
  - W1C at edge M drops o_IRQ after edge M, unless the compare still holds, in which case it sets again at M+1.
- Reset is asynchronous: it clears all state immediately, including an ack in flight.

## Test plan
- Reset, then read all 8 offsets: data 0 everywhere except PRESCALE=PRESCALE_RST and MTIMECMP_LO/HI=0xFFFFFFFF. Each access acks exactly 1 cycle after i_STB, and o_TAGN echoes i_TAGN.
- Prescaler: write PRESCALE=3, then CTRL=1, then run 40 cycles. Read MTIME_LO: it equals floor(elapsed/4). With PRESCALE=0 it advances 1 per cycle.
- Byte enables: write 0xAABBCCDD to MTIMECMP_LO with i_SEL=4'b0101, starting from all-ones. Read back 0xFFBBFFDD.
- Tear-free 64-bit read: load MTIME=0x00000000_FFFFFFFE with EN=1 and PRESCALE=0. Read LO, then HI two cycles later. The pair is consistent (HI=0 paired with LO 0xFFFFFFFF, or HI=1 paired with a small LO), never HI=1 paired with 0xFFFFFFFF.
- Interrupt with W1C race:
  - Set MTIMECMP=10 and CTRL=3. o_IRQ rises 1 cycle after mtime reads 10.
  - W1C STATUS while mtime>=10: PENDING re-sets.
  - After setting MTIMECMP=all-ones, W1C clears it and o_IRQ=0.
- AUTORELOAD and mid-op reset:
  - Set CTRL=7 and MTIMECMP=5: mtime cycles 0..5,0. PENDING sets on each pass.
  - Assert i_RST mid-access: o_ACK drops at once, and state returns to reset values.

Source files
------------

// File: rtl/wishbone_timer.sv
// -----------------------------------------------------------------------------
// wishbone_timer
//
// Wishbone single-beat responder holding a 64-bit machine timer (mtime) with a
// compare register (mtimecmp), a 16-bit prescaler and a level interrupt.
//
// Register map, selected by i_ADDR[4:2]:
//   0 CTRL        bit0 EN, bit1 IRQ_EN, bit2 AUTORELOAD
//   1 STATUS      bit0 PENDING (write 1 to clear)
//   2 PRESCALE    [15:0]
//   3 MTIME_LO    read also latches mtime[63:32] into the HI shadow
//   4 MTIME_HI    reads return the shadow
//   5 MTIMECMP_LO
//   6 MTIMECMP_HI
//   7 unmapped    reads 0, writes ignored, still acknowledged
//
// Ports:
//   i_CLK, i_RST       clock, asynchronous active-high reset
//   i_ADDR             byte address (only [4:2] decoded)
//   i_DATA / o_DATA    write data / registered read data (valid with o_ACK)
//   i_WE, i_SEL        write enable, byte enables for writes
//   i_STB, i_CYC       strobe, bus cycle
//   o_ACK              one-cycle acknowledge, one cycle after the request
//   i_TAGN / o_TAGN    request tag, echoed alongside o_ACK
//   o_IRQ              PENDING & IRQ_EN
// -----------------------------------------------------------------------------
module wishbone_timer #(
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [15:0] PRESCALE_RST = 16'h0000
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [31:0]           i_DATA,
    output logic [31:0]           o_DATA,
    input  logic                  i_WE,
    input  logic [3:0]            i_SEL,
    input  logic                  i_STB,
    input  logic                  i_CYC,
    output logic                  o_ACK,
    input  logic                  i_TAGN,
    output logic                  o_TAGN,
    output logic                  o_IRQ
);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_STATUS   = 3'd1,
        REG_PRESCALE = 3'd2,
        REG_MTIME_LO = 3'd3,
        REG_MTIME_HI = 3'd4,
        REG_CMP_LO   = 3'd5,
        REG_CMP_HI   = 3'd6,
        REG_UNMAPPED = 3'd7
    } reg_e;

    // Replace only the bytes whose enable is set.
    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    logic        ack_q,      ack_d;
    logic [31:0] data_q,     data_d;
    logic        tagn_q,     tagn_d;
    logic [2:0]  ctrl_q,     ctrl_d;
    logic        pending_q,  pending_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q,     pcnt_d;
    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_q,   shadow_d;

    logic        req, wr, rd, tick, clear;
    logic [31:0] rdata;
    logic [31:0] prescale_w;
    reg_e        reg_idx;

    // Address bits outside [4:2] are deliberately not decoded.
    logic unused_addr;
    assign unused_addr = ^{i_ADDR[ADDR_WIDTH-1:5], i_ADDR[1:0]};

    assign req     = i_CYC & i_STB & ~ack_q;
    assign wr      = req & i_WE;
    assign rd      = req & ~i_WE;
    assign reg_idx = reg_e'(i_ADDR[4:2]);
    assign tick    = ctrl_q[0] && (pcnt_q == prescale_q);

    assign prescale_w = merge32({16'h0000, prescale_q}, i_DATA, {2'b00, i_SEL[1:0]});

    // Read mux uses pre-edge register contents.
    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:     rdata = {29'd0, ctrl_q};
            REG_STATUS:   rdata = {31'd0, pending_q};
            REG_PRESCALE: rdata = {16'd0, prescale_q};
            REG_MTIME_LO: rdata = mtime_q[31:0];
            REG_MTIME_HI: rdata = shadow_q;
            REG_CMP_LO:   rdata = mtimecmp_q[31:0];
            REG_CMP_HI:   rdata = mtimecmp_q[63:32];
            default:      rdata = '0;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        shadow_d   = shadow_q;
        clear      = 1'b0;

        // Timer advance; a bus write to mtime below overrides it.
        if (ctrl_q[0]) begin
            if (tick) begin
                pcnt_d  = '0;
                mtime_d = (ctrl_q[2] && (mtime_q == mtimecmp_q)) ? 64'd0
                                                                   : mtime_q + 64'd1;
            end else begin
                pcnt_d = pcnt_q + 16'd1;
            end
        end

        if (wr) begin
            case (reg_idx)
                REG_CTRL:     if (i_SEL[0]) ctrl_d = i_DATA[2:0];
                REG_STATUS:   clear = i_SEL[0] & i_DATA[0];
                REG_PRESCALE: prescale_d = prescale_w[15:0];
                REG_MTIME_LO: begin
                    mtime_d = {mtime_q[63:32], merge32(mtime_q[31:0], i_DATA, i_SEL)};
                    pcnt_d  = '0;
                end
                REG_MTIME_HI: begin
                    mtime_d = {merge32(mtime_q[63:32], i_DATA, i_SEL), mtime_q[31:0]};
                    pcnt_d  = '0;
                end
                REG_CMP_LO:   mtimecmp_d[31:0]  = merge32(mtimecmp_q[31:0], i_DATA, i_SEL);
                REG_CMP_HI:   mtimecmp_d[63:32] = merge32(mtimecmp_q[63:32], i_DATA, i_SEL);
                default:      ;
            endcase
        end

        // Capture the upper half so a following HI read pairs with this LO.
        if (rd && (reg_idx == REG_MTIME_LO)) shadow_d = mtime_q[63:32];

        // Set has priority over a same-cycle clear.
        pending_d = (mtime_q >= mtimecmp_q) | (pending_q & ~clear);

        ack_d  = req;
        data_d = req ? rdata : 32'd0;
        tagn_d = req ? i_TAGN : 1'b0;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_RST) begin
            ack_q      <= 1'b0;
            data_q     <= '0;
            tagn_q     <= 1'b0;
            ctrl_q     <= '0;
            pending_q  <= 1'b0;
            prescale_q <= PRESCALE_RST;
            pcnt_q     <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            shadow_q   <= '0;
        end else begin
            ack_q      <= ack_d;
            data_q     <= data_d;
            tagn_q     <= tagn_d;
            ctrl_q     <= ctrl_d;
            pending_q  <= pending_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
        end
    end

    assign o_ACK  = ack_q;
    assign o_DATA = data_q;
    assign o_TAGN = tagn_q;
    assign o_IRQ  = pending_q & ctrl_q[1];

endmodule

// File: tb/tb_wishbone_timer.sv
// -----------------------------------------------------------------------------
// tb_wishbone_timer
//
// Self-checking bench for wishbone_timer. Each bus access pushes its expected
// tag/read data onto a scoreboard queue; the entry is popped and compared when
// the acknowledge appears. Timer-dependent expectations are derived from the
// number of enabled clock edges elapsed since the enabling write.
// -----------------------------------------------------------------------------
module tb_wishbone_timer;

    localparam logic [15:0] PRESCALE_RST = 16'h0000;

    localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_PRESCALE = 3'd2,
                           A_MT_LO = 3'd3, A_MT_HI = 3'd4, A_CMP_LO = 3'd5,
                           A_CMP_HI = 3'd6, A_UNMAP = 3'd7;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        logic        tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_o;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack_o;
    logic        tagn;
    logic        tagn_o;
    logic        irq_o;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic tag_r       = 1'b1;

    always #5 clk = ~clk;

    wishbone_timer #(
        .ADDR_WIDTH  (32),
        .PRESCALE_RST(PRESCALE_RST)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .i_ADDR(addr),
        .i_DATA(wdata),
        .o_DATA(rdata_o),
        .i_WE  (we),
        .i_SEL (sel),
        .i_STB (stb),
        .i_CYC (cyc),
        .o_ACK (ack_o),
        .i_TAGN(tagn),
        .o_TAGN(tagn_o),
        .o_IRQ (irq_o)
    );

    // Called 1 time unit after a rising edge; returns 1 time unit after the
    // edge following the acknowledge.
    task automatic bus(input logic we_i, input logic [2:0] idx, input logic [31:0] wd,
                       input logic [3:0] sel_i, input logic chk, input logic [31:0] exp_v,
                       input string name, output logic [31:0] rd);
        exp_t e;
        int   waited;
        e.chk  = chk & ~we_i;
        e.data = exp_v;
        e.tag  = tag_r;
        sb_q.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = we_i;
        addr = {27'd0, idx, 2'b00}; wdata = wd; sel = sel_i; tagn = tag_r;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!ack_o && waited < 4);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        e = sb_q.pop_front();
        rd = rdata_o;
        vectors++;
        if (ack_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ack timeout: ack=%b after %0d cycles, required 1", name, ack_o, waited);
        end else begin
            vectors++;
            if (waited != 1) begin
                miscompares++;
                $display("FAIL %s ack latency: got %0d cycles, required 1", name, waited);
            end
            vectors++;
            if (tagn_o !== e.tag) begin
                miscompares++;
                $display("FAIL %s tag: got %b, required %b", name, tagn_o, e.tag);
            end
            if (e.chk) begin
                vectors++;
                if (rdata_o !== e.data) begin
                    miscompares++;
                    $display("FAIL %s data: got %h, required %h", name, rdata_o, e.data);
                end
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (ack_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ack width: ack=%b one cycle later, required 0", name, ack_o);
        end
        tag_r = ~tag_r;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                      input string name);
        logic [31:0] dummy;
        bus(1'b1, idx, d, s, 1'b0, 32'd0, name, dummy);
    endtask

    task automatic rd_chk(input logic [2:0] idx, input logic [31:0] exp_v, input string name);
        logic [31:0] dummy;
        bus(1'b0, idx, 32'd0, 4'h0, 1'b1, exp_v, name, dummy);
    endtask

    task automatic rd_get(input logic [2:0] idx, input string name, output logic [31:0] v);
        bus(1'b0, idx, 32'd0, 4'h0, 1'b0, 32'd0, name, v);
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_irq(input logic exp_v, input string name);
        vectors++;
        if (irq_o !== exp_v) begin
            miscompares++;
            $display("FAIL %s irq: got %b, required %b", name, irq_o, exp_v);
        end
    endtask

    task automatic test_reset();
        logic [31:0] exp_tab [8];
        exp_tab = '{32'd0, 32'd0, {16'd0, PRESCALE_RST}, 32'd0, 32'd0,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        #1;
        vectors++;
        if ({ack_o, rdata_o, tagn_o, irq_o} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset outputs: ack=%b data=%h tag=%b irq=%b, required all 0",
                     ack_o, rdata_o, tagn_o, irq_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rd_chk(3'(i), exp_tab[i], $sformatf("reset_read[%0d]", i));
    endtask

    task automatic test_prescaler();
        do_reset();
        wr(A_PRESCALE, 32'd3, 4'hF, "prescale_wr");
        wr(A_CTRL, 32'd1, 4'hF, "ctrl_en");
        // 40 enabled edges before the sampling edge of the read.
        idle(39);
        rd_chk(A_MT_LO, 32'd10, "prescale3_mtime");

        do_reset();
        wr(A_CTRL, 32'd1, 4'hF, "ctrl_en_p0");
        idle(9);
        rd_chk(A_MT_LO, 32'd10, "prescale0_mtime_a");
        rd_chk(A_MT_LO, 32'd12, "prescale0_mtime_b");
    endtask

    task automatic test_byte_enable();
        do_reset();
        wr(A_CMP_LO, 32'hAABB_CCDD, 4'b0101, "sel_wr");
        rd_chk(A_CMP_LO, 32'hFFBB_FFDD, "sel_readback");
        rd_chk(A_CMP_HI, 32'hFFFF_FFFF, "sel_hi_untouched");
        wr(A_UNMAP, 32'h1234_5678, 4'hF, "unmapped_wr");
        rd_chk(A_UNMAP, 32'd0, "unmapped_rd");
    endtask

    task automatic test_tear_free();
        logic [31:0] lo, hi;
        do_reset();
        wr(A_PRESCALE, 32'd0, 4'hF, "tear_prescale");
        wr(A_MT_LO, 32'hFFFF_FFFE, 4'hF, "tear_mtime_lo");
        wr(A_CTRL, 32'd1, 4'hF, "tear_en");
        // mtime is 0x0_FFFFFFFF at the LO sample, then carries before HI.
        bus(1'b0, A_MT_LO, 32'd0, 4'h0, 1'b1, 32'hFFFF_FFFF, "tear_lo1", lo);
        bus(1'b0, A_MT_HI, 32'd0, 4'h0, 1'b1, 32'd0, "tear_hi1", hi);
        vectors++;
        if (hi == 32'd1 && lo == 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL tear pair: got hi=%h lo=%h, required a consistent pair", hi, lo);
        end
        rd_chk(A_MT_LO, 32'd3, "tear_lo2");
        rd_chk(A_MT_HI, 32'd1, "tear_hi2");
    endtask

    task automatic test_interrupt();
        do_reset();
        wr(A_CMP_LO, 32'd10, 4'hF, "irq_cmp_lo");
        wr(A_CMP_HI, 32'd0, 4'hF, "irq_cmp_hi");
        wr(A_CTRL, 32'd3, 4'hF, "irq_ctrl");
        // mtime equals k after enabled edge k; pending rises one edge after 10.
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk); #1;
            chk_irq(k >= 11, $sformatf("irq_rise_k%0d", k));
        end
        wr(A_STATUS, 32'd1, 4'h1, "w1c_race");
        chk_irq(1'b1, "w1c_race_irq");
        rd_chk(A_STATUS, 32'd1, "w1c_race_status");
        wr(A_CMP_LO, 32'hFFFF_FFFF, 4'hF, "irq_cmp_lo_max");
        wr(A_CMP_HI, 32'hFFFF_FFFF, 4'hF, "irq_cmp_hi_max");
        wr(A_STATUS, 32'd1, 4'h1, "w1c_clear");
        chk_irq(1'b0, "w1c_clear_irq");
        rd_chk(A_STATUS, 32'd0, "w1c_clear_status");
    endtask

    task automatic test_autoreload();
        do_reset();
        wr(A_CMP_LO, 32'd5, 4'hF, "ar_cmp_lo");
        wr(A_CMP_HI, 32'd0, 4'hF, "ar_cmp_hi");
        wr(A_CTRL, 32'd7, 4'hF, "ar_ctrl");
        // After enabled edge k, mtime = k mod 6; read j samples edge 2j-1.
        for (int j = 1; j <= 6; j++)
            rd_chk(A_MT_LO, 32'((2 * j - 1) % 6), $sformatf("ar_mtime_%0d", j));
        wr(A_STATUS, 32'd1, 4'h1, "ar_w1c");
        rd_chk(A_STATUS, 32'd0, "ar_status_cleared");
        idle(2);
        rd_chk(A_STATUS, 32'd1, "ar_status_next_pass");
        chk_irq(1'b1, "ar_irq");
    endtask

    task automatic test_mid_reset();
        int waited;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = {27'd0, A_CMP_LO, 2'b00}; tagn = 1'b1;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!ack_o && waited < 4);
        vectors++;
        if (ack_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset ack before reset: got %b, required 1", ack_o);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({ack_o, rdata_o, tagn_o, irq_o} !== 35'd0) begin
            miscompares++;
            $display("FAIL mid_reset async clear: ack=%b data=%h tag=%b irq=%b, required all 0",
                     ack_o, rdata_o, tagn_o, irq_o);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_chk(A_CTRL, 32'd0, "mid_reset_ctrl");
        rd_chk(A_CMP_LO, 32'hFFFF_FFFF, "mid_reset_cmp_lo");
        rd_chk(A_MT_LO, 32'd0, "mid_reset_mtime");
        rd_chk(A_STATUS, 32'd0, "mid_reset_status");
        chk_irq(1'b0, "mid_reset_irq");
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = '0; tagn = 1'b0;
        test_reset();
        test_prescaler();
        test_byte_enable();
        test_tear_free();
        test_interrupt();
        test_autoreload();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
